fp16_vec_accum: RTL and testbench
=================================

Name: fp16_vec_accum

Overview:
- Downstream consumer of the FP8 vector multiplier. Takes its 4-lane FP16 product vector {qd,qc,qb,qa} each beat and accumulates each lane independently across a burst, which forms 4 parallel dot-product partial sums.
- Sits between the multiplier and the result writeback path.
- Uses valid/ready on both sides and holds the finished sums until the sink takes them.

Parameters:
- LANES, 4, number of FP16 lanes; lane i = bits [16i+15:16i], lane 0 = product of vector element a.
- CNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_last  input  1  beat is the final beat of the burst; sampled with in_valid.
- prod  input  16*LANES  FP16 product vector.
- out_valid  output  1  accumulated result available.
- out_ready  input  1  sink accepts the result.
- acc  output  16*LANES  accumulated FP16 vector.
- beats  output  CNT_W  beats accepted in the current or held burst; saturates at all-ones.

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, acc=0, beats=0, first=1.
- States:
  - IDLE: no burst open.
  - ACCUM: burst open.
  - HOLD: result presented.
- Accept means in_valid && in_ready. in_ready = (state != HOLD), a combinational function of the registered state only.
- On accept:
  - If first=1: acc lanes <= prod lanes, unmodified, with no add applied. beats <= 1. first <= 0.
  - Otherwise: acc lane <= fp16_add(acc lane, prod lane). beats <= beats+1, saturating.
  - State goes to ACCUM, or to HOLD if in_last=1.
- Single-beat burst: in_last on the first beat passes prod straight through to HOLD.
- Latency: acc updates on the clock edge that accepts the beat. out_valid=1 in the cycle after the last beat is accepted.
- HOLD:
  - acc, beats and out_valid are stable and in_ready=0.
  - On out_valid && out_ready: state <= IDLE, out_valid <= 0, first <= 1.
  - acc and beats are retained until the next accept overwrites them.
- No simultaneous accept and drain is possible, because in_ready=0 in HOLD. The earliest a new burst can start is the cycle after the drain.
- in_valid while in HOLD is ignored and does not update the counter.
- Reset mid-burst discards the partial sums, with no result emitted.
- fp16_add rules, applied per lane and purely combinational before the acc register:
  - An operand with exp==0 is treated as zero (subnormals flushed, sign ignored).
  - An operand with exp==31 is saturated; the multiplier emits exp 31 on overflow.
    - One saturated operand: result = {its sign, 5'h1F, 10'h0}.
    - Both saturated: result = {sign of acc lane, 5'h1F, 10'h0}.
  - Normal path:
    - Use 11-bit significands with the implicit 1.
    - Shift the smaller-magnitude operand right by the exponent difference. A difference of 13 or more contributes 0 plus sticky.
    - Add or subtract by sign, normalize with a leading-zero count, and apply rounding (see Optional Feature).
  - Exact cancellation gives +0 (16'h0000).
  - If the result exponent after rounding is ≥31, saturate to {sign, 5'h1F, 10'h0}.
  - If the result exponent is ≤0, flush to {sign, 15'h0}.
  - The result sign is the sign of the larger-magnitude operand.

Optional Feature:
- Macro: FP16ACC_RNE_EN.
- Defined: round to nearest, ties to even, using guard, round and sticky bits kept through alignment and normalization. A mantissa carry-out from rounding increments the exponent and re-checks saturation.
- Undefined: round toward zero; the shifted-out bits are discarded.
- The handshake, latency and special-value rules are identical in both builds.

Test Plan:
- Single beat: prod lanes {0x4200,0x4000,0x3C00,0xBC00} with in_last -> the next cycle has out_valid=1, acc identical to the input, beats=1.
- Four beats of 0x3C00 in all lanes, last on beat 4 -> acc lanes=0x4400 (4.0), beats=4. Beats arrive back-to-back with in_ready=1 throughout.
- Cancellation: 0x3C00 then 0xBC00 -> acc=0x0000. Saturation: 0x7BFF then 0x7BFF -> 0x7C00. Saturated input: 0x7C00 then 0x3C00 -> 0x7C00. Subnormal input: 0x3C00 then 0x0001 -> 0x3C00.
- Rounding: 0x3C01 then 0x1000 (a tie) -> 0x3C01 without the macro, 0x3C02 with FP16ACC_RNE_EN.
- Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 and acc/beats unchanged. On the out_ready pulse, one drain happens, then in_ready=1 the next cycle and the first beat replaces acc.
- Reset mid-burst: assert rst after 2 beats -> outputs go to 0 immediately without waiting for a clock edge. The next burst starts clean with first=1 and beats=1.

Source files
------------

// File: rtl/fp16_vec_accum.sv
// fp16_vec_accum: per-lane FP16 accumulator for a burst of product beats.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_last/prod
// carry product beats in; out_valid/out_ready/acc/beats present the
// finished per-lane sums and the saturating beat count.
// Option: define FP16ACC_RNE_EN for round-to-nearest-even; otherwise the
// adder truncates (round toward zero).
module fp16_vec_accum #(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [16*LANES-1:0]  prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*LANES-1:0]  acc,
    output logic [CNT_W-1:0]     beats
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic                  first_q, first_d;
    logic                  out_valid_q, out_valid_d;
    logic [16*LANES-1:0]   acc_q, acc_d;
    logic [16*LANES-1:0]   sum;
    logic [CNT_W-1:0]      beats_q, beats_d;
    logic                  accept;

    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] lz;
        lz = 4'd0;
        // Last hit wins, so this ends on the highest set bit.
        for (int i = 0; i < 14; i++) begin
            if (v[i]) lz = 4'(13 - i);
        end
        return lz;
    endfunction

    function automatic logic [15:0] fp16_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [4:0]         ea, eb, eh, el, d;
        logic [10:0]        mh, ml;
        logic               sh, sl, a_ge, inc;
        logic [23:0]        wide;
        logic [13:0]        big, sml, n;
        logic [14:0]        s;
        logic [3:0]         lz;
        logic signed [6:0]  e;
        logic [10:0]        mant;
        logic [11:0]        mr;
        logic [15:0]        r;

        ea = a[14:10];
        eb = b[14:10];
        r  = 16'h0000;

        if (ea == 5'h1F && eb == 5'h1F) begin
            r = {a[15], 5'h1F, 10'h0};
        end else if (ea == 5'h1F) begin
            r = {a[15], 5'h1F, 10'h0};
        end else if (eb == 5'h1F) begin
            r = {b[15], 5'h1F, 10'h0};
        end else if (ea == 5'h0 && eb == 5'h0) begin
            r = 16'h0000;
        end else if (ea == 5'h0) begin
            r = b;
        end else if (eb == 5'h0) begin
            r = a;
        end else begin
            a_ge = (a[14:0] >= b[14:0]);
            sh   = a_ge ? a[15] : b[15];
            sl   = a_ge ? b[15] : a[15];
            eh   = a_ge ? ea : eb;
            el   = a_ge ? eb : ea;
            mh   = a_ge ? {1'b1, a[9:0]} : {1'b1, b[9:0]};
            ml   = a_ge ? {1'b1, b[9:0]} : {1'b1, a[9:0]};
            d    = eh - el;

            // 11-bit significand + guard, round, sticky.
            big  = {mh, 3'b000};
            wide = {ml, 13'b0} >> d;
            if (d > 5'd12) begin
                sml = 14'd1;
            end else begin
                sml = {wide[23:11], |wide[10:0]};
            end

            if (sh == sl) begin
                s = {1'b0, big} + {1'b0, sml};
            end else begin
                s = {1'b0, big} - {1'b0, sml};
            end

            if (s == 15'd0) begin
                r = 16'h0000;
            end else begin
                lz = 4'd0;
                if (s[14]) begin
                    n = {s[14:2], |s[1:0]};
                    e = $signed({2'b00, eh}) + 7'sd1;
                end else begin
                    lz = lzc14(s[13:0]);
                    n  = s[13:0] << lz;
                    e  = $signed({2'b00, eh}) - $signed({3'b000, lz});
                end

                mant = n[13:3];
`ifdef FP16ACC_RNE_EN
                inc = n[2] & (n[1] | n[0] | mant[0]);
`else
                inc = 1'b0;
`endif
                mr = {1'b0, mant} + {11'd0, inc};
                if (mr[11]) begin
                    mant = mr[11:1];
                    e    = e + 7'sd1;
                end else begin
                    mant = mr[10:0];
                end

                if (e >= 7'sd31) begin
                    r = {sh, 5'h1F, 10'h0};
                end else if (e <= 7'sd0) begin
                    r = {sh, 15'h0};
                end else begin
                    r = {sh, e[4:0], mant[9:0]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[16*i +: 16] = fp16_add(acc_q[16*i +: 16], prod[16*i +: 16]);
        end
    end

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        beats_d     = beats_q;

        if (accept) begin
            first_d = 1'b0;
            if (first_q) begin
                acc_d   = prod;
                beats_d = CNT_W'(1);
            end else begin
                acc_d = sum;
                if (beats_q != {CNT_W{1'b1}}) begin
                    beats_d = beats_q + CNT_W'(1);
                end
            end
            state_d     = in_last ? HOLD : ACCUM;
            out_valid_d = in_last;
        end else if (out_valid_q && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            first_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            beats_q     <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign beats     = beats_q;

endmodule

// File: tb/tb_fp16_vec_accum.sv
// tb_fp16_vec_accum: scoreboard bench for fp16_vec_accum.
// Expected sums are hand-derived FP16 constants queued per burst.
module tb_fp16_vec_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [63:0] prod;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] acc;
    logic [7:0]  beats;

    int n_vec;
    int n_err;

    logic [71:0] sb_q[$];

    fp16_vec_accum #(
        .LANES(4),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .prod     (prod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc      (acc),
        .beats    (beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [71:0] got,
        input logic [71:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard drain: compare whenever the sink takes a result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 72'd1, 72'd0);
            end else begin
                logic [71:0] e;
                e = sb_q.pop_front();
                check("sb_acc", {8'h0, acc}, {8'h0, e[71:8]});
                check("sb_beats", {64'h0, beats}, {64'h0, e[7:0]});
            end
        end
    end

    task automatic beat(
        input  logic [63:0] p,
        input  logic        l,
        output int          waits
    );
        logic ok;
        waits    = 0;
        in_valid = 1'b1;
        prod     = p;
        in_last  = l;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end while (!ok && waits < 50);
        if (!ok) check("beat_timeout", 72'd0, 72'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain;
        int k;
        k = 0;
        while ((out_valid || sb_q.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (out_valid || sb_q.size() != 0) begin
            check("drain_timeout", 72'd0, 72'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    logic [63:0] rnd_exp;
    logic [63:0] x_vec;
    logic [63:0] y_vec;
    int          w;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        prod      = '0;
        out_ready = 1'b1;
`ifdef FP16ACC_RNE_EN
        rnd_exp = {4{16'h3C02}};
`else
        rnd_exp = {4{16'h3C01}};
`endif

        #1;
        check("rst_in_ready", {71'd0, in_ready}, 72'd1);
        check("rst_out_valid", {71'd0, out_valid}, 72'd0);
        check("rst_acc", {8'h0, acc}, 72'd0);
        check("rst_beats", {64'h0, beats}, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat pass-through.
        x_vec = {16'h4200, 16'h4000, 16'h3C00, 16'hBC00};
        sb_q.push_back({x_vec, 8'd1});
        beat(x_vec, 1'b1, w);
        check("single_out_valid", {71'd0, out_valid}, 72'd1);
        wait_drain();

        // Four back-to-back ones per lane.
        sb_q.push_back({{4{16'h4400}}, 8'd4});
        for (int i = 0; i < 4; i++) begin
            beat({4{16'h3C00}}, i == 3, w);
            check("b2b_ready", 72'(w), 72'd1);
        end
        wait_drain();

        // Lanes: cancel, overflow, saturated in, subnormal in.
        sb_q.push_back({16'h3C00, 16'h7C00, 16'h7C00, 16'h0000, 8'd2});
        beat({16'h3C00, 16'h7C00, 16'h7BFF, 16'h3C00}, 1'b0, w);
        beat({16'h0001, 16'h3C00, 16'h7BFF, 16'hBC00}, 1'b1, w);
        wait_drain();

        // Mixed signs and renormalization after subtraction.
        sb_q.push_back({16'h4000, 16'h3C00, 16'hBC00, 16'h4200, 8'd2});
        beat({16'h3C00, 16'h4400, 16'hC000, 16'h3C00}, 1'b0, w);
        beat({16'h3C00, 16'hC200, 16'h3C00, 16'h4000}, 1'b1, w);
        wait_drain();

        // Rounding tie.
        sb_q.push_back({rnd_exp, 8'd2});
        beat({4{16'h3C01}}, 1'b0, w);
        beat({4{16'h1000}}, 1'b1, w);
        wait_drain();

        // Backpressure in HOLD.
        out_ready = 1'b0;
        x_vec = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        y_vec = {4{16'h3C00}};
        sb_q.push_back({x_vec, 8'd1});
        beat(x_vec, 1'b1, w);
        in_valid = 1'b1;
        prod     = y_vec;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {71'd0, in_ready}, 72'd0);
            check("bp_acc", {8'h0, acc}, {8'h0, x_vec});
            check("bp_beats", {64'h0, beats}, 72'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after", {71'd0, in_ready}, 72'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_new_acc", {8'h0, acc}, {8'h0, y_vec});
        check("bp_new_beats", {64'h0, beats}, 72'd1);
        check("bp_sb_empty", 72'(sb_q.size()), 72'd0);
        out_ready = 1'b1;
        sb_q.push_back({{4{16'h4000}}, 8'd2});
        beat(y_vec, 1'b1, w);
        wait_drain();

        // Reset mid-burst, then a clean single beat.
        beat({4{16'h3C00}}, 1'b0, w);
        beat({4{16'h3C00}}, 1'b0, w);
        rst = 1'b1;
        #1;
        check("mrst_acc", {8'h0, acc}, 72'd0);
        check("mrst_beats", {64'h0, beats}, 72'd0);
        check("mrst_ready", {71'd0, in_ready}, 72'd1);
        check("mrst_valid", {71'd0, out_valid}, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.push_back({{4{16'h4000}}, 8'd1});
        beat({4{16'h4000}}, 1'b1, w);
        wait_drain();

        // Beat counter saturation on a long burst of zeros.
        sb_q.push_back({64'h0, 8'hFF});
        for (int i = 0; i < 300; i++) begin
            beat(64'h0, i == 299, w);
        end
        wait_drain();

        check("final_sb_empty", 72'(sb_q.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
